// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver.
// Holds the receive FSM state encoding, the default frame width and a
// helper that sizes the bit counter.
package shift_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

    // Counter must hold the value WIDTH, so size it for WIDTH+1 states.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial receive bus: line/strobe/direction and ack in, word plus status out.
// slave  : receiver side (samples sin/sen/msb_first/ack, drives q/valid/status).
// master : line driver / consumer side (the opposite directions).
interface shift_deserializer_if
    import shift_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             sin;
    logic             sen;
    logic             msb_first;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             frame_err;
    logic             overrun;

    modport slave (
        input  sin,
        input  sen,
        input  msb_first,
        input  ack,
        output q,
        output valid,
        output frame_err,
        output overrun
    );

    modport master (
        output sin,
        output sen,
        output msb_first,
        output ack,
        input  q,
        input  valid,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/shift_deserializer_sipo_shift_reg.sv
// Bidirectional serial-in shift register, one bit per enabled cycle.
// Latency: sr reflects the shifted-in bit one clock after en=1.
// Backpressure: none; shifts whenever en is high.
// Ports: clk, rst (sync active-high), en (shift strobe), dir (1 = new bit
// enters at LSB so the first bit ends at MSB), sin (serial bit), sr (contents).
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] sr
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            if (dir) begin
                sr_d = {sr_q[WIDTH-2:0], sin};
            end else begin
                sr_d = {sin, sr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr = sr_q;
endmodule

// File: rtl/shift_deserializer.sv
// Framed serial receiver: start bit, WIDTH data bits, stop bit -> parallel word.
// Latency: q/valid/frame_err/overrun update on the edge sampling the stop bit.
// Backpressure: none on the line; a good frame finding valid=1 and no ack is dropped with overrun.
// Ports: clk, rst (sync active-high); bus (slave modport) carries sin, sen,
// msb_first, ack in and q, valid, frame_err, overrun out.
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    shift_deserializer_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             shift_en;
    logic [WIDTH-1:0] sr;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sr (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .dir (dir_q),
        .sin (bus.sin),
        .sr  (sr)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        hold_d      = hold_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        shift_en    = 1'b0;

        // Consumer ack clears valid; a completion on the same edge below
        // overrides this by setting valid again.
        if (bus.ack && valid_q) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.sen && !bus.sin) begin
                    state_d = DATA;
                    dir_d   = bus.msb_first;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (bus.sen) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bus.sen) begin
                    state_d = IDLE;
                    if (bus.sin) begin
                        // sr already holds the last data bit here.
                        if (!valid_q || bus.ack) begin
                            hold_d  = sr;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            hold_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            hold_q      <= hold_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.q         = hold_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed frames from the test plan plus
// randomized frames, checked against a word-level model of the receiver.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_shift_deserializer;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Word-level model state.
    logic [W-1:0] exp_q;
    logic         exp_valid;

    shift_deserializer_if #(.WIDTH(W)) bus ();

    shift_deserializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame of `word`. Bits are laid out on the line from the
    // transmitter's point of view; the model only knows the word itself.
    task automatic send_frame(input logic [W-1:0] word, input bit msb,
                              input bit stop_ok, input int gap,
                              input bit ack_stop, input bit scramble_dir,
                              input bit rand_ack, input string name);
        logic [W+1:0] bits;
        logic         exp_fe;
        logic         exp_ovr;
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) begin
            bits[i+1] = msb ? word[W-1-i] : word[i];
        end
        bits[W+1] = stop_ok;
        for (int i = 0; i < W + 2; i++) begin
            bus.sen       = 1'b1;
            bus.sin       = bits[i];
            bus.ack       = (i == W + 1) ? ack_stop : 1'b0;
            bus.msb_first = (i == 0) ? msb : (scramble_dir ? 1'($urandom_range(0, 1)) : msb);
            step();
            if (i == 0) begin
                checks++;
                if ({bus.frame_err, bus.overrun} !== 2'b00) begin
                    errors++;
                    $display("FAIL %s pulse_len fe/ovr=%b want 00", name, {bus.frame_err, bus.overrun});
                end
            end
            if (i == W + 1) begin
                exp_fe  = 1'b0;
                exp_ovr = 1'b0;
                if (stop_ok) begin
                    if (!exp_valid || ack_stop) begin
                        exp_q     = word;
                        exp_valid = 1'b1;
                    end else begin
                        exp_ovr = 1'b1;
                    end
                end else begin
                    exp_fe = 1'b1;
                    if (ack_stop) exp_valid = 1'b0;
                end
                checks++;
                if ({bus.q, bus.valid, bus.frame_err, bus.overrun} !== {exp_q, exp_valid, exp_fe, exp_ovr}) begin
                    errors++;
                    $display("FAIL %s q=%h v=%b fe=%b ovr=%b want q=%h v=%b fe=%b ovr=%b",
                             name, bus.q, bus.valid, bus.frame_err, bus.overrun,
                             exp_q, exp_valid, exp_fe, exp_ovr);
                end
            end else begin
                for (int g = 0; g < gap; g++) begin
                    bus.sen = 1'b0;
                    bus.sin = 1'($urandom_range(0, 1));
                    bus.ack = rand_ack ? ($urandom_range(0, 3) == 0) : 1'b0;
                    step();
                    if (bus.ack && exp_valid) exp_valid = 1'b0;
                    bus.ack = 1'b0;
                    checks++;
                    if ({bus.q, bus.valid} !== {exp_q, exp_valid}) begin
                        errors++;
                        $display("FAIL %s gap q=%h v=%b want q=%h v=%b",
                                 name, bus.q, bus.valid, exp_q, exp_valid);
                    end
                end
            end
        end
        bus.sen = 1'b0;
        bus.sin = 1'b1;
        bus.ack = 1'b0;
    endtask

    task automatic do_ack(input string name);
        bus.sen = 1'b0;
        bus.ack = 1'b1;
        step();
        bus.ack   = 1'b0;
        exp_valid = 1'b0;
        checks++;
        if ({bus.q, bus.valid, bus.frame_err, bus.overrun} !== {exp_q, 3'b000}) begin
            errors++;
            $display("FAIL %s q=%h v=%b fe=%b ovr=%b want q=%h v=0",
                     name, bus.q, bus.valid, bus.frame_err, bus.overrun, exp_q);
        end
    endtask

    task automatic idle_cycle();
        bus.sen = 1'b0;
        bus.sin = 1'b1;
        bus.ack = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sen = 1'b1;
        bus.sin = 1'b0;
        bus.msb_first = 1'b1;
        bus.ack = 1'b0;
        step();
        step();
        checks++;
        if ({bus.q, bus.valid, bus.frame_err, bus.overrun} !== {{W{1'b0}}, 3'b000}) begin
            errors++;
            $display("FAIL reset q=%h v=%b fe=%b ovr=%b want all 0",
                     bus.q, bus.valid, bus.frame_err, bus.overrun);
        end
        rst = 1'b0;
        bus.sen = 1'b0;
        bus.sin = 1'b1;
        exp_q = '0;
        exp_valid = 1'b0;
        step();
    endtask

    task automatic test_msb_first();
        send_frame(8'h97, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, "msb_first");
        idle_cycle();
        checks++;
        if ({bus.q, bus.valid, bus.frame_err, bus.overrun} !== {8'h97, 3'b100}) begin
            errors++;
            $display("FAIL msb_hold q=%h v=%b fe=%b ovr=%b want q=97 v=1",
                     bus.q, bus.valid, bus.frame_err, bus.overrun);
        end
        do_ack("msb_ack");
    endtask

    task automatic test_lsb_first();
        // Same line bits as 8'h97 MSB-first; read LSB-first they give 8'hE9.
        send_frame(8'hE9, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "lsb_first");
        checks++;
        if (bus.q !== 8'hE9) begin
            errors++;
            $display("FAIL lsb_value q=%h want e9", bus.q);
        end
        do_ack("lsb_ack");
    endtask

    task automatic test_bad_stop();
        send_frame(8'h97, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, "bad_stop");
        idle_cycle();
        checks++;
        if ({bus.valid, bus.frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL bad_stop_pulse v=%b fe=%b want 00", bus.valid, bus.frame_err);
        end
        send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, "after_bad");
        do_ack("after_bad_ack");
    endtask

    task automatic test_overrun();
        send_frame(8'h97, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, "ovr_first");
        send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, "ovr_drop");
        idle_cycle();
        checks++;
        if ({bus.q, bus.valid, bus.overrun} !== {8'h97, 2'b10}) begin
            errors++;
            $display("FAIL ovr_hold q=%h v=%b ovr=%b want q=97 v=1 ovr=0",
                     bus.q, bus.valid, bus.overrun);
        end
        send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, "ovr_ack_stop");
        checks++;
        if ({bus.q, bus.valid, bus.overrun} !== {8'h3C, 2'b10}) begin
            errors++;
            $display("FAIL ovr_ack_value q=%h v=%b ovr=%b want q=3c v=1 ovr=0",
                     bus.q, bus.valid, bus.overrun);
        end
        do_ack("ovr_ack");
    endtask

    task automatic test_sparse();
        send_frame(8'h97, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, "sparse");
        checks++;
        if (bus.q !== 8'h97) begin
            errors++;
            $display("FAIL sparse_value q=%h want 97", bus.q);
        end
        do_ack("sparse_ack");
    endtask

    task automatic test_reset_mid_frame();
        logic [W+1:0] bits;
        bits = {2'b11, 8'h5A};
        bus.sen = 1'b1;
        bus.msb_first = 1'b1;
        bus.sin = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.sin = bits[i];
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q = '0;
        exp_valid = 1'b0;
        checks++;
        if ({bus.q, bus.valid, bus.frame_err, bus.overrun} !== {{W{1'b0}}, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid q=%h v=%b fe=%b ovr=%b want all 0",
                     bus.q, bus.valid, bus.frame_err, bus.overrun);
        end
        idle_cycle();
        send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, "post_reset");
        // Idle line with strobe: nothing may start or change.
        for (int i = 0; i < 20; i++) begin
            bus.sen = 1'b1;
            bus.sin = 1'b1;
            step();
            checks++;
            if ({bus.q, bus.valid, bus.frame_err, bus.overrun} !== {8'h3C, 3'b100}) begin
                errors++;
                $display("FAIL idle_line cyc=%0d q=%h v=%b fe=%b ovr=%b want q=3c v=1",
                         i, bus.q, bus.valid, bus.frame_err, bus.overrun);
            end
        end
        do_ack("idle_ack");
    endtask

    task automatic test_back_to_back();
        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, "b2b_0");
        send_frame(8'h0F, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, "b2b_1");
        send_frame(8'hF0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, "b2b_2");
        do_ack("b2b_ack");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            send_frame(W'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) != 0), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 1'b1, 1'b1, "random");
            if ($urandom_range(0, 2) == 0) do_ack("random_ack");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sen = 1'b0;
        bus.sin = 1'b1;
        bus.msb_first = 1'b1;
        bus.ack = 1'b0;
        exp_q = '0;
        exp_valid = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_bad_stop();
        test_overrun();
        test_sparse();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
